// File: rtl/mux_share_arbiter.sv
// Round-robin arbiter for a shared N-input mux, with capped tenure.
// It drives a registered one-hot grant and select, plus a registered mux output with a valid flag.
module mux_share_arbiter #(
   parameter int N        = 4,
   parameter int W        = 8,
   parameter int MAX_HOLD = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [N-1:0]         req,
   input  logic [N*W-1:0]       data,
   output logic [N-1:0]         gnt,
   output logic [$clog2(N)-1:0] sel,
   output logic [W-1:0]         out_data,
   output logic                 out_valid
);

   localparam int SW = $clog2(N);
   localparam int HW = $clog2(MAX_HOLD + 1);

   typedef enum logic {IDLE, BUSY} state_t;

   state_t         state;
   logic [SW-1:0]  owner;
   logic [SW-1:0]  last;
   logic [HW-1:0]  hold_cnt;

   logic [W-1:0]   data_arr [N];
   logic [SW-1:0]  win;
   logic           rel_now;
   logic           take;

   always_comb begin
      for (int i = 0; i < N; i++) begin
         data_arr[i] = data[i*W +: W];
      end
   end

   // Search starts just after the last grantee, so that grantee has the lowest priority.
   always_comb begin
      logic found;
      found = 1'b0;
      win   = '0;
      for (int k = 1; k <= N; k++) begin
         int idx;
         idx = (int'(last) + k) % N;
         if (!found && req[idx[SW-1:0]]) begin
            found = 1'b1;
            win   = idx[SW-1:0];
         end
      end
   end

   always_comb begin
      rel_now = (state == BUSY) && (!req[owner] || hold_cnt == HW'(MAX_HOLD));
      take    = ((state == IDLE) || rel_now) && (|req);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         owner     <= '0;
         last      <= SW'(N - 1);
         hold_cnt  <= '0;
         gnt       <= '0;
         sel       <= '0;
         out_data  <= '0;
         out_valid <= 1'b0;
      end else begin
         out_valid <= (state == BUSY) && req[owner];
         if ((state == BUSY) && req[owner]) begin
            out_data <= data_arr[sel];
         end

         // A new tenure starts from IDLE or on release, with no gap in between.
         if (take) begin
            state    <= BUSY;
            owner    <= win;
            last     <= win;
            hold_cnt <= HW'(1);
            gnt      <= {{(N-1){1'b0}}, 1'b1} << win;
            sel      <= win;
         end else if (state == IDLE || rel_now) begin
            state    <= IDLE;
            hold_cnt <= '0;
            gnt      <= '0;
         end else begin
            hold_cnt <= hold_cnt + HW'(1);
         end
      end
   end

endmodule

// File: tb/tb_mux_share_arbiter.sv
// Testbench for mux_share_arbiter: directed scenarios followed by random traffic.
// A behavioural round-robin model in the bench predicts every output.
module tb_mux_share_arbiter;

   localparam int N        = 4;
   localparam int W        = 8;
   localparam int MAX_HOLD = 4;

   logic           clk = 1'b0;
   logic           rst;
   logic [N-1:0]   req;
   logic [N*W-1:0] data;
   logic [N-1:0]   gnt;
   logic [1:0]     sel;
   logic [W-1:0]   out_data;
   logic           out_valid;

   int vectors     = 0;
   int miscompares = 0;

   bit             m_busy;
   int             m_owner;
   int             m_last;
   int             m_cnt;
   logic [N-1:0]   m_gnt;
   logic [1:0]     m_sel;
   logic [W-1:0]   m_out_data;
   logic           m_out_valid;

   mux_share_arbiter #(.N(N), .W(W), .MAX_HOLD(MAX_HOLD)) dut (
      .clk       (clk),
      .rst       (rst),
      .req       (req),
      .data      (data),
      .gnt       (gnt),
      .sel       (sel),
      .out_data  (out_data),
      .out_valid (out_valid)
   );

   always #5 clk = ~clk;

   function automatic int rr_pick(input int from, input logic [N-1:0] r);
      for (int k = 1; k <= N; k++) begin
         if (r[(from + k) % N]) return (from + k) % N;
      end
      return -1;
   endfunction

   // Model of one clock edge, using the inputs that were present before that edge.
   task automatic model_step(input logic r, input logic [N-1:0] q, input logic [N*W-1:0] d);
      logic v;
      if (r) begin
         m_busy = 0; m_owner = 0; m_last = N - 1; m_cnt = 0;
         m_gnt = '0; m_sel = '0; m_out_data = '0; m_out_valid = 1'b0;
      end else begin
         v = m_busy && q[m_owner];
         if (v) m_out_data = d[int'(m_sel)*W +: W];
         m_out_valid = v;
         if (!m_busy || !q[m_owner] || m_cnt == MAX_HOLD) begin
            if (q != 0) begin
               m_owner = rr_pick(m_last, q);
               m_last  = m_owner;
               m_cnt   = 1;
               m_busy  = 1;
            end else begin
               m_busy = 0;
               m_cnt  = 0;
            end
         end else begin
            m_cnt++;
         end
         if (m_busy) begin
            m_gnt = 4'(1 << m_owner);
            m_sel = 2'(m_owner);
         end else begin
            m_gnt = '0;
         end
      end
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic checkOutput();
      check("gnt", 32'(gnt), 32'(m_gnt));
      check("sel", 32'(sel), 32'(m_sel));
      check("out_valid", 32'(out_valid), 32'(m_out_valid));
      check("out_data", 32'(out_data), 32'(m_out_data));
   endtask

   task automatic applyStimulus(input logic r, input logic [N-1:0] q);
      logic [N*W-1:0] d;
      d    = $urandom;
      rst  = r;
      req  = q;
      data = d;
      @(posedge clk);
      model_step(r, q, d);
      #1;
      checkOutput();
   endtask

   initial begin
      logic [N-1:0] rq;

      applyStimulus(1'b1, 4'b0000);
      applyStimulus(1'b1, 4'b1111);
      check("reset_gnt", 32'(gnt), 32'h0);
      check("reset_valid", 32'(out_valid), 32'h0);

      // Single requester: regrant to itself every MAX_HOLD cycles with no gap.
      for (int i = 0; i < 10; i++) begin
         applyStimulus(1'b0, 4'b0001);
         if (i == 0) begin
            check("single_first_gnt", 32'(gnt), 32'h1);
            check("single_first_valid", 32'(out_valid), 32'h0);
         end
         if (i >= 1) check("single_valid_cont", 32'(out_valid), 32'h1);
      end

      for (int i = 0; i < 20; i++) applyStimulus(1'b0, 4'b1111);

      applyStimulus(1'b0, 4'b0000);
      check("idle_gnt", 32'(gnt), 32'h0);
      check("idle_valid", 32'(out_valid), 32'h0);
      applyStimulus(1'b0, 4'b0000);

      // Early release: owner 2 drops its request while requester 0 is waiting.
      applyStimulus(1'b1, 4'b0000);
      applyStimulus(1'b0, 4'b0100);
      check("early_owner2", 32'(gnt), 32'h4);
      applyStimulus(1'b0, 4'b0100);
      applyStimulus(1'b0, 4'b0001);
      check("early_gnt", 32'(gnt), 32'h1);
      check("early_gap", 32'(out_valid), 32'h0);
      applyStimulus(1'b0, 4'b0001);
      check("early_resume", 32'(out_valid), 32'h1);

      // Wrap-around: requester 0 beats 3 after reset, and 3 follows once 0 releases.
      applyStimulus(1'b1, 4'b0000);
      for (int i = 0; i < 5; i++) begin
         applyStimulus(1'b0, 4'b1001);
         if (i == 0) check("wrap_first", 32'(gnt), 32'h1);
         if (i == 4) check("wrap_second", 32'(gnt), 32'h8);
      end

      // Reset in the third cycle of a tenure.
      applyStimulus(1'b1, 4'b0000);
      for (int i = 0; i < 3; i++) applyStimulus(1'b0, 4'b1111);
      applyStimulus(1'b1, 4'b1111);
      check("midrst_gnt", 32'(gnt), 32'h0);
      check("midrst_sel", 32'(sel), 32'h0);
      check("midrst_data", 32'(out_data), 32'h0);
      check("midrst_valid", 32'(out_valid), 32'h0);
      applyStimulus(1'b0, 4'b1111);
      check("midrst_regrant", 32'(gnt), 32'h1);

      rq = 4'b1111;
      for (int i = 0; i < 300; i++) begin
         if ($urandom_range(0, 3) == 0) rq = 4'($urandom_range(0, 15));
         applyStimulus(($urandom_range(0, 59) == 0), rq);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/mux_share_arbiter.md
# mux_share_arbiter

Round-robin arbiter and sequencer for a shared N-input select mux. Up to N requesters each present a request and a data word. The block grants one requester at a time and drives the mux select. It registers the selected word onto a single output with a valid flag. Tenure is capped so no requester can monopolise the mux.

## Interface
- N, default 4: number of requesters, 2..16.
- W, default 8: data width per requester.
- MAX_HOLD, default 4: maximum consecutive granted cycles per tenure, at least 1.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- req  input  N  request lines; bit i belongs to requester i.
- data  input  N*W  flattened data; requester i occupies bits [i*W +: W].
- gnt  output  N  one-hot registered grant, or all-zero when idle.
- sel  output  $clog2(N)  registered mux select, equal to the index of the granted requester.
- out_data  output  W  registered shared-mux output.
- out_valid  output  1  qualifies out_data.

## Operation
- States: IDLE and BUSY.
- Internal registers:
  - owner: index of the current grantee.
  - last: index of the most recent grantee.
  - hold_cnt: width $clog2(MAX_HOLD+1), counts granted cycles in the current tenure.
- Round-robin search:
  - Order is last+1, last+2, …, wrapping modulo N, ending at last itself.
  - The first set req bit in that order wins.
  - last has the lowest priority, so it can win again only if it is the sole requester.
- IDLE:
  - gnt = 0.
  - If req != 0, the search winner becomes owner; set last = owner, hold_cnt = 1, go to BUSY.
- BUSY, release condition: req[owner] == 0, or hold_cnt == MAX_HOLD.
  - On release with req != 0: new search from last (the current owner); new owner takes the grant on the next cycle with no idle gap; hold_cnt = 1.
  - On release with req == 0: go to IDLE; gnt = 0 next cycle.
  - No release: hold_cnt increments; owner is unchanged.
- gnt and sel always reflect owner while in BUSY. In IDLE, gnt = 0 and sel holds its last value.
- Data path:
  - Each cycle: out_data <= data[sel] and out_valid <= (state == BUSY) && req[owner].
  - out_data is updated only when out_valid is being set; otherwise it holds.
- A requester that drops req mid-tenure:
  - loses the grant at the next edge;
  - the cycle in which req is low produces out_valid = 0.
- req bits for non-owners do not affect the current tenure.

## Timing
- Reset values:
  - gnt = 0, sel = 0, out_data = 0, out_valid = 0.
  - state = IDLE, hold_cnt = 0.
  - last = N-1, so requester 0 has top priority after reset.
- Reset asserted mid-tenure returns every register to its reset value at that edge. Outputs are zero in the following cycle regardless of req.
- Grant latency: req sampled high at edge k in IDLE gives gnt valid after edge k; the first out_valid follows after edge k+1.
- Back-to-back handover: the last cycle of tenure A is followed directly by the first cycle of tenure B.
- Maximum tenure is exactly MAX_HOLD cycles of gnt. With MAX_HOLD = 1, the grant rotates every cycle among active requesters.
- Simultaneous release by the owner and new requests: the search uses req sampled in that same cycle.
- Wrap-around: with last = N-1, the search starts at index 0.

## Test plan
- Reset then single requester: N=4, MAX_HOLD=4, req=0001 held for 10 cycles.
  - Expect gnt=0001, sel=0 one cycle after req.
  - Expect a regrant with no gap every 4 cycles; out_valid continuous from cycle 2; out_data tracks data[0] with 1-cycle delay.
- All request: req=1111 held.
  - Expect grant order 0,1,2,3,0,…; 4 cycles each; no idle cycles between tenures.
- Early release: owner 2 drops req after 2 cycles while req[0] is high.
  - Expect gnt=0001 on the next edge, a single out_valid=0 cycle, and hold_cnt restarting at 1.
- Wrap and fairness: last=3, req=1001 raised together.
  - Expect requester 0 to win before 3; requester 3 wins only after 0 releases.
- Idle return: sole owner drops req and no other requests are pending.
  - Expect gnt=0 and out_valid=0 next cycle; sel and out_data held.
- Reset mid-operation: assert rst during the 3rd cycle of a tenure with req=1111.
  - Expect all outputs 0 after that edge.
  - After rst is released, requester 0 is granted first.
